// File: rtl/dpb_slot_scheduler.sv
// Ring scheduler for DPB slots between the MJPEG writer and the UDP sender.
// Writer allocates/commits slots in ring order; the reader offers, takes and releases them.
module dpb_slot_scheduler #(
  parameter int unsigned SLOT_NUM = 16,
  parameter int unsigned SLOT_W   = 4
) (
  input  logic              i_pclk,
  input  logic              i_rst,
  input  logic              i_wr_frame_start,
  input  logic              i_wr_alloc_req,
  output logic              o_wr_alloc_ack,
  output logic [SLOT_W-1:0] o_wr_slot,
  input  logic              i_wr_commit,
  input  logic [11:0]       i_wr_commit_len,
  input  logic              i_wr_commit_last,
  output logic              o_rd_valid,
  output logic [SLOT_W-1:0] o_rd_slot,
  output logic [11:0]       o_rd_len,
  output logic              o_rd_last,
  output logic [7:0]        o_rd_udp_rank,
  output logic [14:0]       o_rd_frame_rank,
  input  logic              i_rd_take,
  input  logic              i_rd_release,
  output logic [SLOT_W:0]   o_free_cnt,
  output logic              o_drop,
  output logic              o_error
);

  localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(SLOT_NUM - 1);
  localparam logic [SLOT_W:0]   FullCnt  = (SLOT_W + 1)'(SLOT_NUM);
  localparam logic [SLOT_W:0]   CntOne   = (SLOT_W + 1)'(1);

  typedef enum logic [1:0] {W_IDLE, W_HOLD, W_DROP}   wr_state_e;
  typedef enum logic [1:0] {R_EMPTY, R_OFFER, R_BUSY} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [SLOT_W-1:0] alloc_ptr_q, alloc_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
  logic [SLOT_W:0]   free_cnt_q, free_cnt_d;
  logic [7:0]        udp_rank_q, udp_rank_d;
  logic [14:0]       frame_rank_q, frame_rank_d;
  logic              wr_ack_q, wr_ack_d, error_q;
  logic              wr_err, rd_err, alloc_ok, commit_ok, slot_freed, release_ok;
  logic              load_desc, clear_desc, len_ok;

  // Descriptor store; only the valid bits need reset, contents are qualified by them
  logic [SLOT_NUM-1:0] slot_vld_q;
  logic [11:0]         slot_len_q   [SLOT_NUM];
  logic                slot_last_q  [SLOT_NUM];
  logic [7:0]          slot_udp_q   [SLOT_NUM];
  logic [14:0]         slot_frame_q [SLOT_NUM];

  logic [SLOT_W-1:0] rd_slot_q;
  logic [11:0]       rd_len_q;
  logic              rd_last_q;
  logic [7:0]        rd_udp_q;
  logic [14:0]       rd_frame_q;

  function automatic logic [SLOT_W-1:0] ptr_inc(input logic [SLOT_W-1:0] p);
    return (p == LastSlot) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [SLOT_W-1:0] ptr_dec(input logic [SLOT_W-1:0] p);
    return (p == '0) ? LastSlot : p - 1'b1;
  endfunction

  assign len_ok     = (i_wr_commit_len != 12'd0) && (i_wr_commit_len <= 12'd2048);
  assign rd_ptr_inc = ptr_inc(rd_ptr_q);

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_EMPTY;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    wr_state_d   = wr_state_q;
    alloc_ptr_d  = alloc_ptr_q;
    wr_slot_d    = wr_slot_q;
    udp_rank_d   = udp_rank_q;
    frame_rank_d = frame_rank_q;
    wr_ack_d     = 1'b0;
    wr_err       = 1'b0;
    alloc_ok     = 1'b0;
    commit_ok    = 1'b0;
    slot_freed   = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (i_wr_frame_start) udp_rank_d = '0;
        if (i_wr_commit) wr_err = 1'b1;
        if (i_wr_alloc_req) begin
          if (free_cnt_q != '0) begin
            alloc_ok    = 1'b1;
            wr_ack_d    = 1'b1;
            wr_slot_d   = alloc_ptr_q;
            alloc_ptr_d = ptr_inc(alloc_ptr_q);
            wr_state_d  = W_HOLD;
          end else begin
            wr_err     = 1'b1;
            wr_state_d = W_DROP;
          end
        end
      end
      W_HOLD: begin
        if (i_wr_alloc_req) wr_err = 1'b1;
        // The held slot is always alloc_ptr-1, so freeing it is a pointer step back
        if (i_wr_frame_start) begin
          slot_freed  = 1'b1;
          alloc_ptr_d = ptr_dec(alloc_ptr_q);
          udp_rank_d  = '0;
          wr_state_d  = W_IDLE;
        end else if (i_wr_commit) begin
          wr_state_d = W_IDLE;
          if (len_ok) begin
            commit_ok = 1'b1;
            if (i_wr_commit_last) begin
              udp_rank_d   = '0;
              frame_rank_d = frame_rank_q + 15'd1;
            end else begin
              udp_rank_d = udp_rank_q + 8'd1;
            end
          end else begin
            slot_freed  = 1'b1;
            alloc_ptr_d = ptr_dec(alloc_ptr_q);
            wr_err      = 1'b1;
          end
        end
      end
      W_DROP: begin
        if (i_wr_frame_start) begin
          udp_rank_d   = '0;
          frame_rank_d = frame_rank_q + 15'd1;
          wr_state_d   = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_err     = 1'b0;
    release_ok = 1'b0;
    load_desc  = 1'b0;
    clear_desc = 1'b0;
    unique case (rd_state_q)
      R_EMPTY: begin
        rd_err = i_rd_take | i_rd_release;
        if (slot_vld_q[rd_ptr_q]) begin
          rd_state_d = R_OFFER;
          load_desc  = 1'b1;
        end
      end
      R_OFFER: begin
        rd_err = i_rd_release;
        if (i_rd_take) rd_state_d = R_BUSY;
      end
      R_BUSY: begin
        rd_err = i_rd_take;
        if (i_rd_release) begin
          release_ok = 1'b1;
          rd_ptr_d   = rd_ptr_inc;
          if (slot_vld_q[rd_ptr_inc]) begin
            rd_state_d = R_OFFER;
            load_desc  = 1'b1;
          end else begin
            rd_state_d = R_EMPTY;
            clear_desc = 1'b1;
          end
        end
      end
      default: rd_state_d = R_EMPTY;
    endcase
  end

  // Alloc is judged on the registered count, so a same-cycle release nets to zero
  always_comb begin
    free_cnt_d = free_cnt_q;
    if (alloc_ok)   free_cnt_d = free_cnt_d - CntOne;
    if (release_ok) free_cnt_d = free_cnt_d + CntOne;
    if (slot_freed) free_cnt_d = free_cnt_d + CntOne;
  end

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      alloc_ptr_q  <= '0;
      rd_ptr_q     <= '0;
      wr_slot_q    <= '0;
      free_cnt_q   <= FullCnt;
      udp_rank_q   <= '0;
      frame_rank_q <= '0;
      wr_ack_q     <= 1'b0;
      error_q      <= 1'b0;
      slot_vld_q   <= '0;
      rd_slot_q    <= '0;
      rd_len_q     <= '0;
      rd_last_q    <= 1'b0;
      rd_udp_q     <= '0;
      rd_frame_q   <= '0;
    end else begin
      alloc_ptr_q  <= alloc_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_slot_q    <= wr_slot_d;
      free_cnt_q   <= free_cnt_d;
      udp_rank_q   <= udp_rank_d;
      frame_rank_q <= frame_rank_d;
      wr_ack_q     <= wr_ack_d;
      error_q      <= wr_err | rd_err;
      if (commit_ok)  slot_vld_q[wr_slot_q] <= 1'b1;
      if (release_ok) slot_vld_q[rd_ptr_q]  <= 1'b0;
      if (load_desc) begin
        rd_slot_q  <= rd_ptr_d;
        rd_len_q   <= slot_len_q[rd_ptr_d];
        rd_last_q  <= slot_last_q[rd_ptr_d];
        rd_udp_q   <= slot_udp_q[rd_ptr_d];
        rd_frame_q <= slot_frame_q[rd_ptr_d];
      end else if (clear_desc) begin
        rd_slot_q  <= '0;
        rd_len_q   <= '0;
        rd_last_q  <= 1'b0;
        rd_udp_q   <= '0;
        rd_frame_q <= '0;
      end
    end
  end

  always_ff @(posedge i_pclk) begin
    if (commit_ok) begin
      slot_len_q[wr_slot_q]   <= i_wr_commit_len;
      slot_last_q[wr_slot_q]  <= i_wr_commit_last;
      slot_udp_q[wr_slot_q]   <= udp_rank_q;
      slot_frame_q[wr_slot_q] <= frame_rank_q;
    end
  end

  always_comb begin
    o_rd_valid      = (rd_state_q == R_OFFER);
    o_drop          = (wr_state_q == W_DROP);
    o_wr_alloc_ack  = wr_ack_q;
    o_wr_slot       = wr_slot_q;
    o_free_cnt      = free_cnt_q;
    o_error         = error_q;
    o_rd_slot       = rd_slot_q;
    o_rd_len        = rd_len_q;
    o_rd_last       = rd_last_q;
    o_rd_udp_rank   = rd_udp_q;
    o_rd_frame_rank = rd_frame_q;
  end

endmodule

// File: tb/tb_dpb_slot_scheduler.sv
// Directed bench for dpb_slot_scheduler: a vector table for the basic handshake
// plus hand-written sequences for ring fill, overflow, wrap, bad lengths and reset.
module tb_dpb_slot_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, alloc_req, commit, commit_last, take, release_s;
  logic [11:0] commit_len;
  logic        ack, rvalid, rlast, drop, err;
  logic [3:0]  wslot, rslot;
  logic [11:0] rlen;
  logic [7:0]  rudp;
  logic [14:0] rframe;
  logic [4:0]  free_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dpb_slot_scheduler #(.SLOT_NUM(16), .SLOT_W(4)) dut (
    .i_pclk           (clk),
    .i_rst            (rst),
    .i_wr_frame_start (frame_start),
    .i_wr_alloc_req   (alloc_req),
    .o_wr_alloc_ack   (ack),
    .o_wr_slot        (wslot),
    .i_wr_commit      (commit),
    .i_wr_commit_len  (commit_len),
    .i_wr_commit_last (commit_last),
    .o_rd_valid       (rvalid),
    .o_rd_slot        (rslot),
    .o_rd_len         (rlen),
    .o_rd_last        (rlast),
    .o_rd_udp_rank    (rudp),
    .o_rd_frame_rank  (rframe),
    .i_rd_take        (take),
    .i_rd_release     (release_s),
    .o_free_cnt       (free_cnt),
    .o_drop           (drop),
    .o_error          (err)
  );

  typedef struct {
    logic        a, c;
    logic [11:0] len;
    logic        last, tk, rl, fs;
    logic        ack;
    logic [3:0]  ws;
    logic        rv;
    logic [3:0]  rs;
    logic [11:0] rlen;
    logic        rlast;
    logic [7:0]  rudp;
    logic [14:0] rfr;
    logic [4:0]  fc;
    logic        drop, err;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input int a, c, len, last, tk, rl, fs, e_ack, ws, rv, rs,
                              e_rlen, e_rlast, e_rudp, rfr, fc, e_drop, e_err);
    vec_t v;
    v.a = a[0]; v.c = c[0]; v.len = len[11:0]; v.last = last[0];
    v.tk = tk[0]; v.rl = rl[0]; v.fs = fs[0];
    v.ack = e_ack[0]; v.ws = ws[3:0]; v.rv = rv[0]; v.rs = rs[3:0];
    v.rlen = e_rlen[11:0]; v.rlast = e_rlast[0]; v.rudp = e_rudp[7:0];
    v.rfr = rfr[14:0]; v.fc = fc[4:0]; v.drop = e_drop[0]; v.err = e_err[0];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic a, c, input logic [11:0] len, input logic last, tk, rl, fs);
    alloc_req = a; commit = c; commit_len = len; commit_last = last;
    take = tk; release_s = rl; frame_start = fs;
    tick();
    alloc_req = 0; commit = 0; commit_len = '0; commit_last = 0;
    take = 0; release_s = 0; frame_start = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input int idx, input vec_t v);
    chk($sformatf("row%0d ack", idx), ack, v.ack);
    chk($sformatf("row%0d wr_slot", idx), wslot, v.ws);
    chk($sformatf("row%0d rd_valid", idx), rvalid, v.rv);
    chk($sformatf("row%0d rd_slot", idx), rslot, v.rs);
    chk($sformatf("row%0d rd_len", idx), rlen, v.rlen);
    chk($sformatf("row%0d rd_last", idx), rlast, v.rlast);
    chk($sformatf("row%0d udp_rank", idx), rudp, v.rudp);
    chk($sformatf("row%0d frame_rank", idx), rframe, v.rfr);
    chk($sformatf("row%0d free_cnt", idx), free_cnt, v.fc);
    chk($sformatf("row%0d drop", idx), drop, v.drop);
    chk($sformatf("row%0d error", idx), err, v.err);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " ack"}, ack, 0);
    chk({tag, " wr_slot"}, wslot, 0);
    chk({tag, " rd_valid"}, rvalid, 0);
    chk({tag, " rd_slot"}, rslot, 0);
    chk({tag, " rd_len"}, rlen, 0);
    chk({tag, " rd_last"}, rlast, 0);
    chk({tag, " udp_rank"}, rudp, 0);
    chk({tag, " frame_rank"}, rframe, 0);
    chk({tag, " free_cnt"}, free_cnt, 16);
    chk({tag, " drop"}, drop, 0);
    chk({tag, " error"}, err, 0);
  endtask

  initial begin
    logic [3:0] es;
    // fields: a c len last tk rl fs | ack ws rv rs rlen rlast rudp rfr fc drop err
    tbl[0]  = mk(1, 0,    0, 0, 0, 0, 0,  1, 0, 0, 0,    0, 0, 0, 0, 15, 0, 0);
    tbl[1]  = mk(0, 1, 1400, 0, 0, 0, 0,  0, 0, 0, 0,    0, 0, 0, 0, 15, 0, 0);
    tbl[2]  = mk(0, 0,    0, 0, 0, 0, 0,  0, 0, 1, 0, 1400, 0, 0, 0, 15, 0, 0);
    tbl[3]  = mk(1, 0,    0, 0, 0, 0, 0,  1, 1, 1, 0, 1400, 0, 0, 0, 14, 0, 0);
    tbl[4]  = mk(0, 1,  600, 1, 0, 0, 0,  0, 1, 1, 0, 1400, 0, 0, 0, 14, 0, 0);
    tbl[5]  = mk(0, 0,    0, 0, 1, 0, 0,  0, 1, 0, 0, 1400, 0, 0, 0, 14, 0, 0);
    tbl[6]  = mk(0, 0,    0, 0, 1, 0, 0,  0, 1, 0, 0, 1400, 0, 0, 0, 14, 0, 1);
    tbl[7]  = mk(0, 0,    0, 0, 0, 1, 0,  0, 1, 1, 1,  600, 1, 1, 0, 15, 0, 0);
    tbl[8]  = mk(0, 0,    0, 0, 1, 0, 0,  0, 1, 0, 1,  600, 1, 1, 0, 15, 0, 0);
    tbl[9]  = mk(0, 0,    0, 0, 0, 1, 0,  0, 1, 0, 0,    0, 0, 0, 0, 16, 0, 0);
    tbl[10] = mk(1, 0,    0, 0, 0, 0, 0,  1, 2, 0, 0,    0, 0, 0, 0, 15, 0, 0);
    tbl[11] = mk(0, 1,  100, 0, 0, 0, 0,  0, 2, 0, 0,    0, 0, 0, 0, 15, 0, 0);
    tbl[12] = mk(0, 0,    0, 0, 0, 0, 0,  0, 2, 1, 2,  100, 0, 0, 1, 15, 0, 0);
    tbl[13] = mk(0, 0,    0, 0, 0, 1, 0,  0, 2, 1, 2,  100, 0, 0, 1, 15, 0, 1);
    tbl[14] = mk(0, 1,   50, 0, 0, 0, 0,  0, 2, 1, 2,  100, 0, 0, 1, 15, 0, 1);
    tbl[15] = mk(0, 0,    0, 0, 1, 0, 0,  0, 2, 0, 2,  100, 0, 0, 1, 15, 0, 0);
    tbl[16] = mk(0, 0,    0, 0, 0, 1, 0,  0, 2, 0, 0,    0, 0, 0, 0, 16, 0, 0);

    alloc_req = 0; commit = 0; commit_len = '0; commit_last = 0;
    take = 0; release_s = 0; frame_start = 0;
    rst = 1;
    tick();
    tick();
    chk_reset("reset");
    rst = 0;

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].a, tbl[i].c, tbl[i].len, tbl[i].last, tbl[i].tk, tbl[i].rl, tbl[i].fs);
      chk_vec(i, tbl[i]);
    end

    // Realign both pointers to 15 so the fill crosses the wrap
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("align%0d wr_slot", i), wslot, i);
      cyc(0, 1, 10, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("align%0d rd_slot", i), rslot, i);
      cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
    end
    chk("align free_cnt", free_cnt, 16);

    for (int i = 0; i < 16; i++) begin
      es = 4'((15 + i) % 16);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("fill%0d ack", i), ack, 1);
      chk($sformatf("fill%0d wr_slot", i), wslot, es);
      cyc(0, 1, 20, 0, 0, 0, 0);
    end
    chk("full free_cnt", free_cnt, 0);
    chk("full rd_valid", rvalid, 1);
    chk("full rd_slot", rslot, 15);
    chk("full udp_rank", rudp, 15);

    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("ovf ack", ack, 0);
    chk("ovf error", err, 1);
    chk("ovf drop", drop, 1);
    chk("ovf free_cnt", free_cnt, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("ovf error pulse", err, 0);
    chk("ovf drop held", drop, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("drop alloc error", err, 0);
    chk("drop alloc ack", ack, 0);
    cyc(0, 1, 20, 0, 0, 0, 0);
    chk("drop commit error", err, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("drop exit", drop, 0);
    chk("drop exit error", err, 0);

    // Release slot 15 with a same-cycle alloc while the ring is full
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("take15 rd_valid", rvalid, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    chk("rel0 ack", ack, 0);
    chk("rel0 error", err, 1);
    chk("rel0 drop", drop, 1);
    chk("rel0 free_cnt", free_cnt, 1);
    chk("rel0 rd_valid", rvalid, 1);
    chk("rel0 rd_slot wrap", rslot, 0);
    chk("rel0 udp_rank", rudp, 16);
    chk("rel0 frame_rank", rframe, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rel0 drop exit", drop, 0);

    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    chk("rel1 ack", ack, 1);
    chk("rel1 wr_slot", wslot, 15);
    chk("rel1 free_cnt", free_cnt, 1);
    chk("rel1 error", err, 0);
    chk("rel1 rd_slot", rslot, 1);
    cyc(0, 1, 30, 1, 0, 0, 0);
    chk("rel1 commit error", err, 0);
    chk("rel1 commit free_cnt", free_cnt, 1);

    for (int k = 1; k < 15; k++) begin
      cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
    end
    chk("drain free_cnt", free_cnt, 15);
    chk("drain rd_valid", rvalid, 1);
    chk("drain rd_slot", rslot, 15);
    chk("drain rd_len", rlen, 30);
    chk("drain rd_last", rlast, 1);
    chk("drain udp_rank", rudp, 0);
    chk("drain frame_rank", rframe, 2);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("empty free_cnt", free_cnt, 16);
    chk("empty rd_valid", rvalid, 0);

    // Illegal commit lengths free the held slot
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("len0 wr_slot", wslot, 0);
    chk("len0 held free_cnt", free_cnt, 15);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("len0 error", err, 1);
    chk("len0 free_cnt", free_cnt, 16);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("len0 rd_valid", rvalid, 0);
    chk("len0 error pulse", err, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("len2049 wr_slot", wslot, 0);
    cyc(0, 1, 2049, 0, 0, 0, 0);
    chk("len2049 error", err, 1);
    chk("len2049 free_cnt", free_cnt, 16);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("len2049 rd_valid", rvalid, 0);
    chk("len2049 drop", drop, 0);

    // Reset while writer and reader both hold a slot
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 50, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("midrst pre wr_slot", wslot, 1);
    chk("midrst pre free_cnt", free_cnt, 14);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk_reset("midrst");
    tick();
    rst = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("post rst ack", ack, 1);
    chk("post rst wr_slot", wslot, 0);
    chk("post rst free_cnt", free_cnt, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
